falafel_wrr_fifo_arbiter: RTL and testbench

Weighted round-robin arbiter that shares one request FIFO write port (alloc or free) between NUM_REQ input queues.
- Replaces fixed-priority selection, which starves high-index queues.
- Each queue may take up to its configured weight of consecutive beats per turn.
- A one-entry output register decouples the arbitration path from the FIFO full signal.
- Sits between the per-queue input parsers/buffers and the alloc/free FIFOs; weights come from the config registers.

---
 rtl/falafel_wrr_fifo_arbiter.sv | 176 +++++++++++++++++
 tb/tb_falafel_wrr_fifo_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/falafel_wrr_fifo_arbiter.sv
// ============================================================================
// falafel_wrr_fifo_arbiter
// ----------------------------------------------------------------------------
// Weighted round-robin arbiter that shares one request FIFO write port
// (alloc or free) between NUM_REQ input queues. Each queue may take up to its
// configured weight of consecutive beats per turn. After that, the turn moves
// to the next valid queue in circular order. This avoids the starvation that
// fixed-priority selection causes for high-index queues.
//
// A one-entry output register sits between the arbiter and the FIFO. The
// arbitration path therefore never depends combinationally on the FIFO
// contents, and the only feedback is the single fifo_full_i bit. Throughput
// is one beat per cycle while the FIFO is not full.
//
// Ports:
//   clk_i            clock
//   rst_i            synchronous reset, active-high
//   req_val_i        per-queue valid
//   req_rdy_o        per-queue ready, one-hot or zero
//   req_size_i       per-queue size/data, queue i at [i*DATA_W +: DATA_W]
//   req_id_i         per-queue message id, queue i at [i*ID_W +: ID_W]
//   weight_i         per-queue max beats per turn (0 behaves as 1)
//   fifo_full_i      downstream FIFO full
//   fifo_write_o     FIFO write strobe
//   fifo_din_size_o  FIFO write data (size)
//   fifo_din_id_o    FIFO write id
//   fifo_src_o       index of the queue that produced the current output beat
// ============================================================================
module falafel_wrr_fifo_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 64,
    parameter int ID_W     = 8,
    parameter int WEIGHT_W = 4,
    localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_val_i,
    output logic [NUM_REQ-1:0]           req_rdy_o,
    input  logic [NUM_REQ*DATA_W-1:0]    req_size_i,
    input  logic [NUM_REQ*ID_W-1:0]      req_id_i,
    input  logic [NUM_REQ*WEIGHT_W-1:0]  weight_i,
    input  logic                         fifo_full_i,
    output logic                         fifo_write_o,
    output logic [DATA_W-1:0]            fifo_din_size_o,
    output logic [ID_W-1:0]              fifo_din_id_o,
    output logic [SRC_W-1:0]             fifo_src_o
);

    // Output register holding the beat presented to the FIFO
    logic                 out_vld;
    logic [DATA_W-1:0]    out_size;
    logic [ID_W-1:0]      out_id;
    logic [SRC_W-1:0]     out_src;

    // Turn bookkeeping: current owner, beats taken so far, turn in progress
    logic [SRC_W-1:0]     ptr;
    logic [WEIGHT_W-1:0]  cnt;
    logic                 turn_act;

    // Per-queue views of the flattened input buses
    logic [WEIGHT_W-1:0]  w_eff    [NUM_REQ];
    logic [DATA_W-1:0]    size_arr [NUM_REQ];
    logic [ID_W-1:0]      id_arr   [NUM_REQ];

    // Arbitration intermediates
    logic                 fifo_write;
    logic                 accept;
    logic                 cont;
    logic                 scan_found;
    logic [SRC_W-1:0]     scan_idx;
    logic                 grant;
    logic [SRC_W-1:0]     sel;
    logic                 transfer;

    // Queue index that lies offs positions after base, wrapping modulo
    // NUM_REQ. Plain integer arithmetic keeps the wrap correct when NUM_REQ
    // is not a power of two.
    function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base,
                                                  input int offs);
        int s;
        s = (int'(base) + offs) % NUM_REQ;
        return SRC_W'(s);
    endfunction

    // Slice the flattened buses into per-queue arrays. A configured weight of
    // zero is promoted to one, so that every queue can always make progress
    // on its turn.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_eff[g]    = (weight_i[g*WEIGHT_W +: WEIGHT_W] == '0)
                             ? WEIGHT_W'(1)
                             : weight_i[g*WEIGHT_W +: WEIGHT_W];
        assign size_arr[g] = req_size_i[g*DATA_W +: DATA_W];
        assign id_arr[g]   = req_id_i[g*ID_W +: ID_W];
    end

    // Output stage. The register drains whenever the FIFO has room. A new
    // beat can be accepted when the register is empty or is being drained in
    // this same cycle. Reset suppresses the write strobe immediately, even
    // before the register itself has been cleared by the clock edge.
    always_comb begin
        fifo_write = out_vld & ~fifo_full_i & ~rst_i;
        accept     = ~out_vld | fifo_write;
    end

    assign fifo_write_o    = fifo_write;
    assign fifo_din_size_o = out_size;
    assign fifo_din_id_o   = out_id;
    assign fifo_src_o      = out_src;

    // Selection.
    // The current owner keeps the port while it stays valid and has beats
    // left in its weight. In every other case a new turn starts with the
    // first valid queue after ptr, and the scan ends with ptr itself.
    // The scan loop runs from the farthest offset down to the nearest one,
    // so the last hit, which is the nearest valid queue, wins. This avoids
    // a separate "already found" chain.
    always_comb begin
        cont       = turn_act && req_val_i[ptr] && (cnt < w_eff[ptr]);
        scan_found = 1'b0;
        scan_idx   = ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_val_i[wrap_idx(ptr, k)]) begin
                scan_found = 1'b1;
                scan_idx   = wrap_idx(ptr, k);
            end
        end
        grant = cont | scan_found;
        sel   = cont ? ptr : scan_idx;
    end

    // Ready is raised only toward the selected queue, and only when the
    // output register can take the beat. A granted queue is valid by
    // construction, so ready alone marks a transfer.
    always_comb begin
        req_rdy_o = '0;
        transfer  = accept & grant & ~rst_i;
        if (transfer) begin
            req_rdy_o[sel] = 1'b1;
        end
    end

    // State update. A transfer loads the output register and advances the
    // turn: it either extends the current turn by one beat or opens a new
    // turn at the selected queue. If the register is draining with nothing
    // behind it, the register empties. With no transfer, the turn state
    // holds as it is.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_vld  <= 1'b0;
            out_size <= '0;
            out_id   <= '0;
            out_src  <= '0;
            ptr      <= SRC_W'(NUM_REQ - 1);
            cnt      <= '0;
            turn_act <= 1'b0;
        end else begin
            if (transfer) begin
                out_vld  <= 1'b1;
                out_size <= size_arr[sel];
                out_id   <= id_arr[sel];
                out_src  <= sel;
                if (cont) begin
                    cnt <= cnt + WEIGHT_W'(1);
                end else begin
                    ptr      <= sel;
                    cnt      <= WEIGHT_W'(1);
                    turn_act <= 1'b1;
                end
            end else if (fifo_write) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_falafel_wrr_fifo_arbiter.sv
// ============================================================================
// tb_falafel_wrr_fifo_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for falafel_wrr_fifo_arbiter.
// A behavioural model tracks the turn owner, the beats taken and the output
// register. A scoreboard queue receives every granted beat and must see that
// beat leave through the FIFO port exactly once and in order. Directed
// scenarios pin grant and write sequences against hand-derived literals.
// A randomized phase then exercises valid, weight, full and reset together.
// ============================================================================
module tb_falafel_wrr_fifo_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int IW = 8;
    localparam int WW = 4;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_val;
    logic [N-1:0]      req_rdy;
    logic [N*DW-1:0]   req_size;
    logic [N*IW-1:0]   req_id;
    logic [N*WW-1:0]   weight;
    logic              fifo_full;
    logic              fifo_write;
    logic [DW-1:0]     din_size;
    logic [IW-1:0]     din_id;
    logic [SW-1:0]     src;

    int assert_count = 0;
    int fail_count   = 0;
    bit rand_ids     = 1'b0;

    typedef struct {
        logic [DW-1:0] size;
        logic [IW-1:0] id;
        int            src;
    } beat_t;

    beat_t          sb [$];
    int             grant_log [$];
    logic [IW-1:0]  write_log [$];

    // Model state, in plain integers: the register contents plus the turn
    // owner, the beats taken in the turn and whether a turn is open.
    bit             m_vld  = 1'b0;
    logic [DW-1:0]  m_size = '0;
    logic [IW-1:0]  m_id   = '0;
    int             m_src  = 0;
    int             m_ptr  = N - 1;
    int             m_cnt  = 0;
    bit             m_act  = 1'b0;

    always #5 clk = ~clk;

    falafel_wrr_fifo_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .ID_W    (IW),
        .WEIGHT_W(WW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_val_i      (req_val),
        .req_rdy_o      (req_rdy),
        .req_size_i     (req_size),
        .req_id_i       (req_id),
        .weight_i       (weight),
        .fifo_full_i    (fifo_full),
        .fifo_write_o   (fifo_write),
        .fifo_din_size_o(din_size),
        .fifo_din_id_o  (din_id),
        .fifo_src_o     (src)
    );

    // Single comparison point: counts it and reports a mismatch
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs shortly after the rising edge, then stop
    // inside the cycle so that callers can inspect combinational outputs
    task automatic applyStimulus(input logic [N-1:0] val, input bit full, input bit r);
        @(posedge clk);
        #1;
        rst       = r;
        req_val   = val;
        fifo_full = full;
        for (int i = 0; i < N; i++) begin
            req_size[i*DW +: DW] = {$urandom, $urandom};
            if (rand_ids) req_id[i*IW +: IW] = 8'($urandom);
        end
        #3;
    endtask

    task automatic applyReset();
        applyStimulus('0, 1'b0, 1'b1);
        applyStimulus('0, 1'b0, 1'b1);
        grant_log.delete();
        write_log.delete();
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic setIdsA();
        for (int i = 0; i < N; i++) req_id[i*IW +: IW] = 8'(8'hA0 + i);
    endtask

    task automatic checkGrantAt(input string tag, input int idx, input int expected);
        checkOutput($sformatf("%s_grant%0d", tag, idx),
                    (grant_log.size() > idx) ? grant_log[idx] : -1, expected);
    endtask

    task automatic checkWriteAt(input string tag, input int idx, input logic [IW-1:0] expected);
        checkOutput($sformatf("%s_write%0d", tag, idx),
                    (write_log.size() > idx) ? 64'(write_log[idx]) : 64'hDEAD, 64'(expected));
    endtask

    // Model and compare process. On each falling edge it derives the
    // expected ready and write outputs from the turn rules, compares them
    // and the output data with the DUT, logs grants and writes, runs the
    // scoreboard, and advances the model by one clock.
    initial begin : model_compare
        int           weff [N];
        int           sel;
        int           gi;
        bit           cont;
        bit           grant;
        bit           accept;
        bit           exp_write;
        logic [N-1:0] exp_rdy;
        beat_t        b;
        forever begin
            @(negedge clk);
            sel = 0; cont = 0; grant = 0; accept = 0;
            exp_write = 0; exp_rdy = '0;
            if (!rst) begin
                for (int i = 0; i < N; i++) begin
                    weff[i] = int'(weight[i*WW +: WW]);
                    if (weff[i] == 0) weff[i] = 1;
                end
                exp_write = m_vld && !fifo_full;
                accept    = !m_vld || exp_write;
                if (m_act && req_val[m_ptr] && m_cnt < weff[m_ptr]) begin
                    cont = 1; grant = 1; sel = m_ptr;
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        if (!grant && req_val[(m_ptr + k) % N]) begin
                            grant = 1; sel = (m_ptr + k) % N;
                        end
                    end
                end
                if (accept && grant) exp_rdy[sel] = 1'b1;
            end

            checkOutput("fifo_write", 64'(fifo_write), 64'(exp_write));
            checkOutput("req_rdy", 64'(req_rdy), 64'(exp_rdy));
            checkOutput("din_size", din_size, m_size);
            checkOutput("din_id", 64'(din_id), 64'(m_id));
            checkOutput("fifo_src", 64'(src), 64'(m_src));

            if (|req_rdy) begin
                gi = 0;
                for (int k = 0; k < N; k++) if (req_rdy[k]) gi = k;
                grant_log.push_back(gi);
            end

            if (fifo_write) begin
                write_log.push_back(din_id);
                if (sb.size() == 0) begin
                    checkOutput("sb_unexpected_write", 64'd1, 64'd0);
                end else begin
                    b = sb.pop_front();
                    checkOutput("sb_size", din_size, b.size);
                    checkOutput("sb_id", 64'(din_id), 64'(b.id));
                    checkOutput("sb_src", 64'(src), 64'(b.src));
                end
            end

            if (rst) begin
                sb.delete();
                m_vld = 0; m_size = '0; m_id = '0; m_src = 0;
                m_ptr = N - 1; m_cnt = 0; m_act = 0;
            end else if (accept && grant) begin
                b.size = req_size[sel*DW +: DW];
                b.id   = req_id[sel*IW +: IW];
                b.src  = sel;
                sb.push_back(b);
                m_vld = 1; m_size = b.size; m_id = b.id; m_src = sel;
                if (cont) begin
                    m_cnt++;
                end else begin
                    m_ptr = sel; m_cnt = 1; m_act = 1;
                end
            end else if (exp_write) begin
                m_vld = 0;
            end
        end
    end

    // Watchdog so that the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, fail count %0d", fail_count);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        int e1 [6]  = '{0, 1, 2, 3, 0, 1};
        int e2 [10] = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1};
        int e3 [6]  = '{0, 1, 2, 3, 0, 1};
        int e5 [7]  = '{0, 0, 1, 1, 1, 1, 0};
        logic [IW-1:0] w1 [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};

        rst = 1'b1; req_val = '0; fifo_full = 1'b0;
        req_size = '0; req_id = '0;
        weight = {N{4'd1}};
        setIdsA();

        // Equal weights, everyone valid: plain round robin starting at 0
        applyReset();
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("t1_first_cycle_write", 64'(fifo_write), 64'd0);
        checkOutput("t1_first_cycle_rdy", 64'(req_rdy), 64'b0001);
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("t1_write_after_one", 64'(fifo_write), 64'd1);
        checkOutput("t1_first_id", 64'(din_id), 64'hA0);
        repeat (4) applyStimulus(4'hF, 1'b0, 1'b0);
        settle();
        for (int i = 0; i < 6; i++) checkGrantAt("t1", i, e1[i]);
        for (int i = 0; i < 5; i++) checkWriteAt("t1", i, w1[i]);

        // Weight 3 on queue 0, zero weights on queues 1 and 3 act as one
        applyReset();
        weight = {4'd0, 4'd1, 4'd0, 4'd3};
        repeat (10) applyStimulus(4'hF, 1'b0, 1'b0);
        settle();
        for (int i = 0; i < 10; i++) checkGrantAt("t2", i, e2[i]);

        // FIFO full for three cycles while the register holds queue 2's beat
        applyReset();
        weight = {N{4'd1}};
        repeat (3) applyStimulus(4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'hF, 1'b1, 1'b0);
            checkOutput("t3_full_write", 64'(fifo_write), 64'd0);
            checkOutput("t3_full_rdy", 64'(req_rdy), 64'd0);
            checkOutput("t3_full_hold_id", 64'(din_id), 64'hA2);
        end
        repeat (3) applyStimulus(4'hF, 1'b0, 1'b0);
        settle();
        for (int i = 0; i < 6; i++) checkGrantAt("t3", i, e3[i]);
        for (int i = 0; i < 5; i++) checkWriteAt("t3", i, w1[i]);
        checkOutput("t3_write_count", 64'(write_log.size()), 64'd5);

        // Only queue 2 valid, weight 2: it wins every cycle
        applyReset();
        weight = {4'd1, 4'd2, 4'd1, 4'd1};
        repeat (6) applyStimulus(4'b0100, 1'b0, 1'b0);
        settle();
        checkOutput("t4_grant_count", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6; i++) checkGrantAt("t4", i, 2);
        for (int i = 0; i < 5; i++) checkWriteAt("t4", i, 8'hA2);

        // Owner drops valid mid-turn, and it waits for its next turn
        applyReset();
        weight = {N{4'd4}};
        repeat (2) applyStimulus(4'b0011, 1'b0, 1'b0);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        repeat (4) applyStimulus(4'b0011, 1'b0, 1'b0);
        settle();
        for (int i = 0; i < 7; i++) checkGrantAt("t5", i, e5[i]);

        // Reset pulse mid-stream with a full output register and ptr at 2
        applyReset();
        weight = {N{4'd1}};
        repeat (3) applyStimulus(4'hF, 1'b0, 1'b0);
        applyStimulus(4'hF, 1'b0, 1'b1);
        checkOutput("t6_reset_write", 64'(fifo_write), 64'd0);
        checkOutput("t6_reset_rdy", 64'(req_rdy), 64'd0);
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("t6_post_reset_write", 64'(fifo_write), 64'd0);
        checkOutput("t6_post_reset_rdy", 64'(req_rdy), 64'b0001);

        // Randomized traffic, checked by the model every cycle
        rand_ids = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] v;
            if ($urandom_range(0, 15) == 0) weight = 16'($urandom);
            v = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            applyStimulus(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
        end
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        settle();
        checkOutput("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
